// File: rtl/instr_decode.sv
//==============================================================================
// Module  : instr_decode
// Brief   : MIPS subset decoder feeding a 2-entry FIFO toward the ALU.
// Revision: 1.0
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module instr_decode #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_ir,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      instr_ID,
  output logic [4:0]       dst,
  output logic [4:0]       src_a,
  output logic [4:0]       src_b,
  output logic [31:0]      imm,
  output logic             use_imm,
  output logic [CNT_W-1:0] err_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  typedef struct packed {
    logic [3:0]  id;
    logic [4:0]  dst;
    logic [4:0]  src_a;
    logic [4:0]  src_b;
    logic [31:0] imm;
    logic        use_imm;
  } dec_t;

  state_t           state_q, state_d;
  dec_t             e0_q, e0_d, e1_q, e1_d;
  logic             in_ready_q, in_ready_d;
  logic [CNT_W-1:0] err_q, err_d;

  dec_t       dec_w;
  logic [3:0] id_w;
  logic       rtype_w, shift_w, itype_w, sext_w, legal_w;
  logic       accept_w, push_w, pop_w;

  // Classify the instruction, then pick fields by class.
  always_comb begin
    id_w    = 4'd0;
    rtype_w = 1'b0;
    shift_w = 1'b0;
    itype_w = 1'b0;
    sext_w  = 1'b0;
    case (in_ir[31:26])
      6'h00: begin
        case (in_ir[5:0])
          6'h20: begin id_w = 4'd1;  rtype_w = 1'b1; end
          6'h22: begin id_w = 4'd2;  rtype_w = 1'b1; end
          6'h21: begin id_w = 4'd3;  rtype_w = 1'b1; end
          6'h23: begin id_w = 4'd4;  rtype_w = 1'b1; end
          6'h24: begin id_w = 4'd7;  rtype_w = 1'b1; end
          6'h25: begin id_w = 4'd8;  rtype_w = 1'b1; end
          6'h00: begin id_w = 4'd11; shift_w = 1'b1; end
          6'h02: begin id_w = 4'd12; shift_w = 1'b1; end
          default: ;
        endcase
      end
      6'h08: begin id_w = 4'd5;  itype_w = 1'b1; sext_w = 1'b1; end
      6'h09: begin id_w = 4'd6;  itype_w = 1'b1; sext_w = 1'b1; end
      6'h0C: begin id_w = 4'd9;  itype_w = 1'b1; end
      6'h0D: begin id_w = 4'd10; itype_w = 1'b1; end
      default: ;
    endcase

    legal_w = rtype_w | shift_w | itype_w;
    dec_w   = '0;
    dec_w.id = id_w;
    if (rtype_w) begin
      dec_w.src_a = in_ir[25:21];
      dec_w.src_b = in_ir[20:16];
      dec_w.dst   = in_ir[15:11];
    end else if (shift_w) begin
      dec_w.src_a   = in_ir[20:16];
      dec_w.dst     = in_ir[15:11];
      dec_w.imm     = {27'd0, in_ir[10:6]};
      dec_w.use_imm = 1'b1;
    end else if (itype_w) begin
      dec_w.src_a   = in_ir[25:21];
      dec_w.dst     = in_ir[20:16];
      dec_w.imm     = sext_w ? {{16{in_ir[15]}}, in_ir[15:0]} : {16'd0, in_ir[15:0]};
      dec_w.use_imm = 1'b1;
    end
  end

  assign accept_w = in_valid && in_ready_q;
  assign push_w   = accept_w && legal_w && !flush;
  assign pop_w    = (state_q != EMPTY) && out_ready;

  always_comb begin
    state_d = state_q;
    e0_d    = e0_q;
    e1_d    = e1_q;
    err_d   = err_q;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: if (push_w) begin
          state_d = ONE;
          e0_d    = dec_w;
        end
        ONE: begin
          if (push_w && pop_w) begin
            e0_d = dec_w;
          end else if (push_w) begin
            state_d = FULL;
            e1_d    = dec_w;
          end else if (pop_w) begin
            state_d = EMPTY;
          end
        end
        FULL: if (pop_w) begin
          state_d = ONE;
          e0_d    = e1_q;
        end
        default: state_d = EMPTY;
      endcase
    end
    // Dropped illegal words are counted, but not when flushed away.
    if (accept_w && !legal_w && !flush && (err_q != '1))
      err_d = err_q + CNT_W'(1);
    in_ready_d = (state_d != FULL);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= EMPTY;
      e0_q       <= '0;
      e1_q       <= '0;
      in_ready_q <= 1'b0;
      err_q      <= '0;
    end else begin
      state_q    <= state_d;
      e0_q       <= e0_d;
      e1_q       <= e1_d;
      in_ready_q <= in_ready_d;
      err_q      <= err_d;
    end
  end

  assign out_valid = (state_q != EMPTY);
  assign in_ready  = in_ready_q;
  assign err_cnt   = err_q;
  assign instr_ID  = out_valid ? {28'd0, e0_q.id} : 32'd0;
  assign dst       = out_valid ? e0_q.dst     : 5'd0;
  assign src_a     = out_valid ? e0_q.src_a   : 5'd0;
  assign src_b     = out_valid ? e0_q.src_b   : 5'd0;
  assign imm       = out_valid ? e0_q.imm     : 32'd0;
  assign use_imm   = out_valid ? e0_q.use_imm : 1'b0;

endmodule

`default_nettype wire

// File: tb/tb_instr_decode.sv
//==============================================================================
// Module  : tb_instr_decode
// Brief   : Scoreboard bench for instr_decode (default and 2-bit counter).
// Revision: 1.0
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_instr_decode;

  logic        clk = 1'b0, reset = 1'b0, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [31:0] in_ir = 32'd0;
  logic        in_ready, out_valid, use_imm;
  logic [31:0] instr_ID, imm;
  logic [4:0]  dst, src_a, src_b;
  logic [15:0] err_cnt;
  logic        in_ready2, out_valid2, use_imm2;
  logic [31:0] instr_ID2, imm2;
  logic [4:0]  dst2, src_a2, src_b2;
  logic [1:0]  err_cnt2;

  instr_decode u_dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_ir(in_ir), .out_valid(out_valid), .out_ready(out_ready), .instr_ID(instr_ID),
    .dst(dst), .src_a(src_a), .src_b(src_b), .imm(imm), .use_imm(use_imm), .err_cnt(err_cnt)
  );

  instr_decode #(.CNT_W(2)) u_dut2 (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready2),
    .in_ir(in_ir), .out_valid(out_valid2), .out_ready(out_ready), .instr_ID(instr_ID2),
    .dst(dst2), .src_a(src_a2), .src_b(src_b2), .imm(imm2), .use_imm(use_imm2), .err_cnt(err_cnt2)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] id;
    logic [4:0]  dst;
    logic [4:0]  sa;
    logic [4:0]  sb;
    logic [31:0] imm;
    logic        u;
  } exp_t;

  exp_t sbq[$];
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic chk(input string nm, input logic [79:0] act, input logic [79:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", nm, act, exp);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] id, input logic [4:0] d, input logic [4:0] a,
                              input logic [4:0] b, input logic [31:0] im, input logic u);
    exp_t e;
    e.id = id; e.dst = d; e.sa = a; e.sb = b; e.imm = im; e.u = u;
    return e;
  endfunction

  // Monitor: head must match scoreboard front every cycle; fields zero when idle.
  initial begin
    forever begin
      @(negedge clk);
      if (out_valid) begin
        if (sbq.size() == 0) begin
          chk("spurious_out", 80'(out_valid), 80'd0);
        end else begin
          chk("head", {instr_ID, dst, src_a, src_b, imm, use_imm}, sbq[0]);
          if (out_ready && !flush) sbq.delete(0);
        end
      end else begin
        chk("idle_zero", {instr_ID, dst, src_a, src_b, imm, use_imm}, 80'd0);
      end
    end
  end

  task automatic send(input logic [31:0] ir, input bit legal, input exp_t e);
    int t = 0;
    in_valid = 1'b1;
    in_ir    = ir;
    @(negedge clk);
    while (!in_ready) begin
      t++;
      if (t > 50) begin
        chk("accept_timeout", 80'd1, 80'd0);
        in_valid = 1'b0;
        return;
      end
      @(negedge clk);
    end
    if (legal) sbq.push_back(e);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  localparam logic [31:0] ADD   = 32'h00221820, ADDI = 32'h2085FFFF, ORI  = 32'h34028000;
  localparam logic [31:0] SLL   = 32'h000220C0, SUB  = 32'h00A43022, ANDI = 32'h3043FF00;
  localparam logic [31:0] SRL   = 32'h00032942, ADDIU = 32'h24E78000, OR_ = 32'h01094025;

  exp_t e_add, e_addi, e_ori, e_sll, e_sub, e_andi, e_srl, e_addiu, e_or;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, want finish");
    $fatal(1);
  end

  initial begin
    e_add   = mk(32'd1,  5'd3, 5'd1, 5'd2, 32'h0,        1'b0);
    e_addi  = mk(32'd5,  5'd5, 5'd4, 5'd0, 32'hFFFFFFFF, 1'b1);
    e_ori   = mk(32'd10, 5'd2, 5'd0, 5'd0, 32'h00008000, 1'b1);
    e_sll   = mk(32'd11, 5'd4, 5'd2, 5'd0, 32'd3,        1'b1);
    e_sub   = mk(32'd2,  5'd6, 5'd5, 5'd4, 32'h0,        1'b0);
    e_andi  = mk(32'd9,  5'd3, 5'd2, 5'd0, 32'h0000FF00, 1'b1);
    e_srl   = mk(32'd12, 5'd5, 5'd3, 5'd0, 32'd5,        1'b1);
    e_addiu = mk(32'd6,  5'd7, 5'd7, 5'd0, 32'hFFFF8000, 1'b1);
    e_or    = mk(32'd8,  5'd8, 5'd8, 5'd9, 32'h0,        1'b0);

    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 80'(in_ready), 80'd0);
    chk("rst_out_valid", 80'(out_valid), 80'd0);
    chk("rst_err_cnt", 80'(err_cnt), 80'd0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("ready_after_reset", 80'(in_ready), 80'd1);

    // Streaming with the consumer always ready.
    out_ready = 1'b1;
    send(ADD, 1'b1, e_add);
    chk("latency1", 80'(out_valid), 80'd1);
    send(ADDI, 1'b1, e_addi);
    send(ORI, 1'b1, e_ori);
    send(SLL, 1'b1, e_sll);
    send(SUB, 1'b1, e_sub);
    send(ANDI, 1'b1, e_andi);
    send(SRL, 1'b1, e_srl);
    send(ADDIU, 1'b1, e_addiu);
    send(OR_, 1'b1, e_or);
    repeat (2) @(posedge clk);
    #1;
    chk("stream_drained", 80'(sbq.size()), 80'd0);

    // Backpressure: two fill the FIFO, the third waits for the consumer.
    out_ready = 1'b0;
    send(ADD, 1'b1, e_add);
    send(SUB, 1'b1, e_sub);
    chk("full_in_ready", 80'(in_ready), 80'd0);
    fork
      begin
        repeat (4) @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join_none
    send(ORI, 1'b1, e_ori);
    repeat (4) @(posedge clk);
    #1;
    chk("backpressure_order", 80'(sbq.size()), 80'd0);

    // Illegal words and counter saturation.
    send(32'hFC000000, 1'b0, '0);
    chk("err_cnt_1", 80'(err_cnt), 80'd1);
    chk("err_cnt2_1", 80'(err_cnt2), 80'd1);
    send(32'h0000002A, 1'b0, '0);
    send(32'h10000000, 1'b0, '0);
    send(32'h0000003F, 1'b0, '0);
    send(32'hFC000000, 1'b0, '0);
    chk("err_cnt_5", 80'(err_cnt), 80'd5);
    chk("err_cnt2_sat", 80'(err_cnt2), 80'd3);

    // Flush in ONE discards the word accepted on the same edge.
    out_ready = 1'b0;
    send(ADD, 1'b1, e_add);
    in_valid = 1'b1; in_ir = SUB; flush = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0; flush = 1'b0;
    sbq.delete();
    chk("flush_one_empty", 80'(out_valid), 80'd0);
    // Flush with an illegal word leaves the counter alone.
    in_valid = 1'b1; in_ir = 32'hFC000000; flush = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0; flush = 1'b0;
    chk("flush_err_hold", 80'(err_cnt), 80'd5);

    // Flush from FULL.
    send(ADD, 1'b1, e_add);
    send(ADDI, 1'b1, e_addi);
    in_valid = 1'b1; in_ir = ORI; flush = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0; flush = 1'b0;
    sbq.delete();
    chk("flush_full_empty", 80'(out_valid), 80'd0);
    chk("flush_full_ready", 80'(in_ready), 80'd1);
    repeat (2) @(posedge clk);
    #1;
    chk("flush_stays_empty", 80'(out_valid), 80'd0);

    // Reset mid-stream with a word in flight.
    send(ADD, 1'b1, e_add);
    send(SUB, 1'b1, e_sub);
    reset = 1'b0; in_valid = 1'b1; in_ir = OR_;
    @(posedge clk);
    #1;
    sbq.delete();
    chk("midrst_fields", {instr_ID, dst, src_a, src_b, imm, use_imm}, 80'd0);
    chk("midrst_flags", 80'({out_valid, in_ready}), 80'd0);
    chk("midrst_err", 80'(err_cnt), 80'd0);
    reset = 1'b1; in_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("midrst_ready", 80'(in_ready), 80'd1);
    chk("midrst_no_flight", 80'(out_valid), 80'd0);
    out_ready = 1'b1;
    send(SLL, 1'b1, e_sll);
    repeat (3) @(posedge clk);
    #1;
    chk("final_drain", 80'(sbq.size()), 80'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
